// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that owns sel/Load/clear of a shared 32-bit dual-input load register.
// Optional feature macro: LOAD_CNT_EN (defined = load_count counts loads, undefined = load_count tied to 0).
module reg_load_arbiter #(
  parameter int GAP   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [1:0]       req,
  input  logic             flush,
  output logic             sel,
  output logic             load,
  output logic             clear_reg,
  output logic [1:0]       ack,
  output logic             busy,
  output logic [CNT_W-1:0] load_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2,
    ST_CLR  = 2'd3
  } state_t;

  localparam logic       GAP_EN   = (GAP > 0) ? 1'b1 : 1'b0;
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state_r;
  state_t     state_s;
  logic       prio_r;
  logic       winner_s;
  logic [3:0] gap_cnt_r;
  logic [3:0] gap_cnt_s;
  logic [1:0] ack_s;

  function automatic logic [1:0] grant_onehot(input logic w);
    grant_onehot = w ? 2'b10 : 2'b01;
  endfunction

  // Next-state, winner selection and gap countdown.
  always_comb begin
    state_s   = state_r;
    winner_s  = prio_r;
    gap_cnt_s = gap_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_s = ST_CLR;
        end else if (req != 2'b00) begin
          state_s = ST_LOAD;
          if (req == 2'b11) begin
            winner_s = prio_r;
          end else begin
            winner_s = req[1];
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (flush) begin
          state_s = ST_CLR;
        end else if (GAP_EN) begin
          state_s   = ST_GAP;
          gap_cnt_s = GAP_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (flush) begin
          state_s = ST_CLR;
        end else if (gap_cnt_r == 4'd0) begin
          state_s = ST_IDLE;
        end else begin
          state_s   = ST_GAP;
          gap_cnt_s = gap_cnt_r - 4'd1;
        end
      end
      ST_CLR: begin
        // A flush seen here is absorbed rather than queued.
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // One-hot grant for the cycle being entered.
  always_comb begin
    if (state_s == ST_LOAD) begin
      ack_s = grant_onehot(winner_s);
    end else begin
      ack_s = 2'b00;
    end
  end

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_r   <= ST_IDLE;
      gap_cnt_r <= 4'd0;
      prio_r    <= 1'b0;
      sel       <= 1'b0;
      load      <= 1'b0;
      clear_reg <= 1'b0;
      ack       <= 2'b00;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      gap_cnt_r <= gap_cnt_s;
      load      <= (state_s == ST_LOAD);
      clear_reg <= (state_s == ST_CLR);
      ack       <= ack_s;
      busy      <= (state_s != ST_IDLE);
      // sel holds its last value outside LOAD.
      if (state_s == ST_LOAD) begin
        sel    <= winner_s;
        prio_r <= ~winner_s;
      end else begin
        sel    <= sel;
        prio_r <= prio_r;
      end
    end
  end

`ifdef LOAD_CNT_EN
  logic [CNT_W-1:0] count_r;

  // Completed-load counter, wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (state_s == ST_LOAD) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign load_count = count_r;
`else
  assign load_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Self-checking bench: three arbiters (GAP=0/CNT_W=4, GAP=3, GAP=5) against a busy-time reference model.
module tb_reg_load_arbiter;

`ifdef LOAD_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  hold;    // busy cycles still owed after the current one begins
    logic        in_clr;
    logic        prio;
    logic        sel;
    logic        load;
    logic        clr;
    logic [1:0]  ack;
    logic        busy;
    logic [15:0] cnt;
  } mstate_t;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic flush = 1'b0;
  logic [1:0] reqa [3];
  logic [1:0] want [3];
  logic rearm = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  mstate_t m [3];

  logic sel0, load0, clr0, busy0; logic [1:0] ack0; logic [3:0]  cnt0;
  logic sel3, load3, clr3, busy3; logic [1:0] ack3; logic [15:0] cnt3;
  logic sel5, load5, clr5, busy5; logic [1:0] ack5; logic [15:0] cnt5;
  logic [21:0] obs [3];
  logic [1:0]  acks [3];

  always #5 clk = ~clk;

  reg_load_arbiter #(.GAP(0), .CNT_W(4)) u0 (
    .clk(clk), .clear_n(clear_n), .req(reqa[0]), .flush(flush), .sel(sel0), .load(load0),
    .clear_reg(clr0), .ack(ack0), .busy(busy0), .load_count(cnt0));
  reg_load_arbiter #(.GAP(3), .CNT_W(16)) u3 (
    .clk(clk), .clear_n(clear_n), .req(reqa[1]), .flush(flush), .sel(sel3), .load(load3),
    .clear_reg(clr3), .ack(ack3), .busy(busy3), .load_count(cnt3));
  reg_load_arbiter #(.GAP(5), .CNT_W(16)) u5 (
    .clk(clk), .clear_n(clear_n), .req(reqa[2]), .flush(flush), .sel(sel5), .load(load5),
    .clear_reg(clr5), .ack(ack5), .busy(busy5), .load_count(cnt5));

  assign obs[0] = {sel0, load0, clr0, ack0, busy0, 12'd0, cnt0};
  assign obs[1] = {sel3, load3, clr3, ack3, busy3, cnt3};
  assign obs[2] = {sel5, load5, clr5, ack5, busy5, cnt5};
  assign acks[0] = ack0;
  assign acks[1] = ack3;
  assign acks[2] = ack5;

  function automatic int gap_of(input int k);
    gap_of = (k == 0) ? 0 : ((k == 1) ? 3 : 5);
  endfunction

  function automatic logic [15:0] mask_of(input int k);
    mask_of = (k == 0) ? 16'h000F : 16'hFFFF;
  endfunction

  function automatic logic [21:0] epack(input mstate_t s);
    epack = {s.sel, s.load, s.clr, s.ack, s.busy, s.cnt};
  endfunction

  // Model: after a grant the arbiter owes 1+GAP busy cycles; a flush while
  // busy (and not already clearing) or idle replaces that with one clear cycle.
  function automatic mstate_t mstep(input mstate_t s, input logic rn, input logic [1:0] r,
                                    input logic f, input int gap, input logic [15:0] mask);
    mstate_t n;
    logic w;
    n = s;
    n.load = 1'b0; n.clr = 1'b0; n.ack = 2'b00;
    if (!rn) begin
      n = '0;
    end else if (s.hold == 8'd0) begin
      if (f) begin
        n.clr = 1'b1; n.hold = 8'd1; n.in_clr = 1'b1;
      end else if (r != 2'b00) begin
        w = (r == 2'b11) ? s.prio : r[1];
        n.load = 1'b1; n.sel = w; n.ack = w ? 2'b10 : 2'b01; n.prio = ~w;
        n.cnt = CNT_ON ? ((s.cnt + 16'd1) & mask) : 16'd0;
        n.hold = 8'(1 + gap); n.in_clr = 1'b0;
      end
    end else if (f && !s.in_clr) begin
      n.clr = 1'b1; n.hold = 8'd1; n.in_clr = 1'b1;
    end else begin
      n.hold = s.hold - 8'd1; n.in_clr = 1'b0;
    end
    n.busy = (n.hold != 8'd0);
    return n;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) m[k] <= mstep(m[k], clear_n, reqa[k], flush, gap_of(k), mask_of(k));
  end

  // Advance to the next falling edge and act as the two requesters of every DUT.
  task automatic tick();
    @(negedge clk);
    cyc++;
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 2; b++) begin
        if (reqa[k][b] && acks[k][b]) begin
          reqa[k][b] = 1'b0;
          if (!rearm) want[k][b] = 1'b0;
        end else if (want[k][b]) begin
          reqa[k][b] = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    for (int k = 0; k < 3; k++) begin reqa[k] = 2'b00; want[k] = 2'b00; end
    tick(); tick();
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== 22'd0) begin
        errors++; $display("FAIL reset dut%0d got %h want %h", k, obs[k], 22'd0);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    rearm = 1'b0;
    want[0] = 2'b01;
    tick();
    tick();
    checks++;
    if ({load0, sel0, ack0, busy0, cnt0} !== {1'b1, 1'b0, 2'b01, 1'b1, CNT_ON ? 4'd1 : 4'd0}) begin
      errors++; $display("FAIL single_load got %b want %b", {load0, sel0, ack0, busy0, cnt0},
                         {1'b1, 1'b0, 2'b01, 1'b1, CNT_ON ? 4'd1 : 4'd0});
    end
    tick();
    checks++;
    if ({load0, busy0} !== 2'b00) begin
      errors++; $display("FAIL single_idle got %b want 00", {load0, busy0});
    end
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== epack(m[k])) begin
          errors++; $display("FAIL model_single dut%0d t=%0d got %h want %h", k, cyc, obs[k], epack(m[k]));
        end
      end
      tick();
    end
  endtask

  task automatic test_alternate();
    int order [$];
    do_reset();
    rearm = 1'b1;
    for (int k = 0; k < 3; k++) want[k] = 2'b11;
    for (int i = 0; i < 30; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== epack(m[k])) begin
          errors++; $display("FAIL model_alt dut%0d t=%0d got %h want %h", k, cyc, obs[k], epack(m[k]));
        end
      end
      if (load0 && order.size() < 4) begin
        order.push_back(ack0 == 2'b10 ? 1 : 0);
        if (order.size() == 4) begin
          checks++;
          if (cnt0 !== (CNT_ON ? 4'd4 : 4'd0)) begin
            errors++; $display("FAIL alt_count got %0d want %0d", cnt0, CNT_ON ? 4 : 0);
          end
        end
      end
    end
    checks++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      errors++; $display("FAIL alt_order got %p want 0,1,0,1", order);
    end
    rearm = 1'b0;
  endtask

  task automatic test_gap();
    int t_load [$];
    do_reset();
    rearm = 1'b1;
    want[1] = 2'b10;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (load3) begin
        t_load.push_back(cyc);
        checks++;
        if ({sel3, ack3} !== 3'b110) begin
          errors++; $display("FAIL gap_grant got %b want 110", {sel3, ack3});
        end
      end
    end
    checks++;
    if (t_load.size() != 3 || t_load[1] - t_load[0] != 5 || t_load[2] - t_load[1] != 5) begin
      errors++; $display("FAIL gap_spacing got %p want spacing 5 x3", t_load);
    end
    rearm = 1'b0;
    want[1] = 2'b00;
  endtask

  task automatic test_flush();
    do_reset();
    want[0] = 2'b01;
    want[2] = 2'b01;
    tick();
    flush = 1'b1;
    tick();
    checks++;
    if ({clr0, load0} !== 2'b10) begin
      errors++; $display("FAIL flush_vs_req got %b want 10", {clr0, load0});
    end
    tick();
    tick();
    checks++;
    if ({load0, ack0} !== 3'b101) begin
      errors++; $display("FAIL flush_then_grant got %b want 101", {load0, ack0});
    end
    tick();
    want[2] = 2'b10;
    tick();
    flush = 1'b1;
    tick();
    checks++;
    if (clr5 !== 1'b1) begin
      errors++; $display("FAIL gap_flush got %b want 1", clr5);
    end
    tick();
    tick();
    checks++;
    if ({load5, ack5} !== 3'b110) begin
      errors++; $display("FAIL gap_flush_grant got %b want 110", {load5, ack5});
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== epack(m[k])) begin
        errors++; $display("FAIL model_flush dut%0d t=%0d got %h want %h", k, cyc, obs[k], epack(m[k]));
      end
    end
  endtask

  task automatic test_wrap_and_midop_reset();
    int n = 0;
    do_reset();
    rearm = 1'b1;
    want[0] = 2'b01;
    for (int i = 0; i < 80 && n < 16; i++) begin
      tick();
      if (load0) begin
        n++;
        checks++;
        if (cnt0 !== (CNT_ON ? 4'(n) : 4'd0)) begin
          errors++; $display("FAIL wrap_count load %0d got %0d want %0d", n, cnt0, CNT_ON ? (n & 15) : 0);
        end
      end
    end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL wrap_timeout got %0d loads want 16", n);
    end
    rearm = 1'b0;
    want[0] = 2'b00;
    while (reqa[0] != 2'b00) tick();
    want[0] = 2'b01;
    tick();
    tick();
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    checks++;
    if (obs[0] !== 22'd0) begin
      errors++; $display("FAIL midop_reset got %h want %h", obs[0], 22'd0);
    end
    want[0] = 2'b11;
    tick();
    tick();
    checks++;
    if ({load0, ack0} !== 3'b101) begin
      errors++; $display("FAIL midop_prio got %b want 101", {load0, ack0});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== epack(m[k])) begin
          errors++; $display("FAIL model_rand dut%0d t=%0d got %h want %h", k, cyc, obs[k], epack(m[k]));
        end
        if ($urandom_range(0, 3) == 0) want[k] = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 49) == 0) rearm = ~rearm;
      flush = ($urandom_range(0, 19) == 0);
      clear_n = ($urandom_range(0, 99) != 0);
    end
    clear_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin reqa[k] = 2'b00; want[k] = 2'b00; end
    test_reset();
    test_single();
    test_alternate();
    test_gap();
    test_flush();
    test_wrap_and_midop_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
